// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter core between NUM_REQ byte requesters.
// Optional macro UART_TX_SCHED_SRC_HDR_EN sends a {4'hA,1'b0,src[2:0]} header frame before each byte.
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [IDX_W-1:0]     active_src,
  output logic                 sched_busy,
  output logic [CNT_W-1:0]     frame_count
);

`ifdef UART_TX_SCHED_SRC_HDR_EN
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GRANT       = 3'd1,
    START       = 3'd2,
    WAIT_HI     = 3'd3,
    WAIT_LO     = 3'd4,
    HDR_START   = 3'd5,
    HDR_WAIT_HI = 3'd6,
    HDR_WAIT_LO = 3'd7
  } state_t;

  logic [7:0] payload_r;

  function automatic logic [7:0] src_header(input logic [IDX_W-1:0] src);
    return {4'hA, 1'b0, 3'(src)};
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } state_t;
`endif

  state_t             state_r;
  state_t             next_s;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W-1:0]   idx_s;
  logic               found_s;
  logic [1:0]         timer_r;
  logic               timeout_s;
  logic               start_next_s;
  logic               wait_hi_s;
  logic               frame_done_s;
  logic [7:0]         grant_byte_s;
  logic [NUM_REQ-1:0] ack_s;

  // Rotating search: scanning from the far end down lets the nearest requester after ptr win.
  always_comb begin
    winner_s = '0;
    idx_s    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx_s = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
      if (req[idx_s]) begin
        winner_s = idx_s;
      end else begin
        winner_s = winner_s;
      end
    end
    found_s      = |req;
    grant_byte_s = req_data[{winner_s, 3'b000} +: 8];
    ack_s           = '0;
    ack_s[winner_s] = 1'b1;
  end

  assign timeout_s = (timer_r == 2'd3);

  // Next-state selection plus the decoded strobes used by the registered outputs.
  always_comb begin
    next_s       = state_r;
    start_next_s = 1'b0;
    wait_hi_s    = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s && !tx_busy) next_s = GRANT;
        else                     next_s = IDLE;
      end
      GRANT: begin
`ifdef UART_TX_SCHED_SRC_HDR_EN
        if (found_s) next_s = HDR_START;
`else
        if (found_s) next_s = START;
`endif
        else         next_s = IDLE;
      end
      START: next_s = WAIT_HI;
      WAIT_HI: begin
        wait_hi_s = 1'b1;
        if (tx_busy)        next_s = WAIT_LO;
        else if (timeout_s) next_s = START;
        else                next_s = WAIT_HI;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          next_s       = IDLE;
          frame_done_s = 1'b1;
        end else begin
          next_s = WAIT_LO;
        end
      end
`ifdef UART_TX_SCHED_SRC_HDR_EN
      HDR_START: next_s = HDR_WAIT_HI;
      HDR_WAIT_HI: begin
        wait_hi_s = 1'b1;
        if (tx_busy)        next_s = HDR_WAIT_LO;
        else if (timeout_s) next_s = HDR_START;
        else                next_s = HDR_WAIT_HI;
      end
      HDR_WAIT_LO: begin
        if (!tx_busy) begin
          next_s       = START;
          frame_done_s = 1'b1;
        end else begin
          next_s = HDR_WAIT_LO;
        end
      end
`endif
      default: next_s = IDLE;
    endcase
`ifdef UART_TX_SCHED_SRC_HDR_EN
    start_next_s = (next_s == START) || (next_s == HDR_START);
`else
    start_next_s = (next_s == START);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= next_s;
  end

  // Registered outputs, grant latching, retry timer and frame counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r       <= IDX_W'(NUM_REQ - 1);
      timer_r     <= 2'd0;
      req_ack     <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      active_src  <= '0;
      sched_busy  <= 1'b0;
      frame_count <= '0;
`ifdef UART_TX_SCHED_SRC_HDR_EN
      payload_r   <= 8'h00;
`endif
    end else begin
      tx_start   <= start_next_s;
      sched_busy <= (next_s != IDLE);
      if (wait_hi_s) timer_r <= timer_r + 2'd1;
      else           timer_r <= 2'd0;
      if (state_r == GRANT && found_s) begin
        req_ack    <= ack_s;
        ptr_r      <= winner_s;
        active_src <= winner_s;
`ifdef UART_TX_SCHED_SRC_HDR_EN
        payload_r  <= grant_byte_s;
        tx_data    <= src_header(winner_s);
`else
        tx_data    <= grant_byte_s;
`endif
      end else begin
        req_ack <= '0;
      end
`ifdef UART_TX_SCHED_SRC_HDR_EN
      // Header done: expose the held payload for the second pass.
      if (state_r == HDR_WAIT_LO && !tx_busy) tx_data <= payload_r;
`endif
      if (frame_done_s) frame_count <= frame_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: requester/core models, round-robin scoreboard, directed scenarios.
// Builds with or without UART_TX_SCHED_SRC_HDR_EN.
module tb_uart_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 4;
`ifdef UART_TX_SCHED_SRC_HDR_EN
  localparam int FPG = 2;
`else
  localparam int FPG = 1;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic [IDX_W-1:0]     active_src;
  logic                 sched_busy;
  logic [CNT_W-1:0]     frame_count;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_ack(req_ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .active_src(active_src),
    .sched_busy(sched_busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         last_grant;
  logic [7:0] exp_q[$];
  logic [7:0] core_log[$];
  int         grant_log[$];
  int         start_cycles[$];
  int         model_frames;
  int         pend_inc;
  int         remaining[NUM_REQ];
  logic [NUM_REQ-1:0] reassert;
  int         core_state;
  int         core_cnt;
  logic [7:0] core_byte;
  int         ignore_starts;
  int         cyc;
  int         prev_fc;
  int         wrap_seen;
  localparam int BUSY_DELAY = 2;
  localparam int BUSY_LEN   = 6;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int expected_winner();
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last_grant + k) % NUM_REQ;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_grant   = NUM_REQ - 1;
    exp_q.delete();
    model_frames = 0;
    pend_inc     = 0;
    reassert     = '0;
    core_state   = 0;
    core_cnt     = 0;
    tx_busy      = 1'b0;
    req          = '0;
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
  endtask

  // One cycle: requesters, core model, scoreboard compare.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pend_inc != 0) begin
      model_frames++;
      pend_inc = 0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reassert[i]) begin
        req_data[8*i +: 8] = req_data[8*i +: 8] + 8'h40;
        req[i]      = 1'b1;
        reassert[i] = 1'b0;
      end
    end
    if (core_state == 1) begin
      core_cnt--;
      if (core_cnt == 0) begin
        tx_busy    = 1'b1;
        core_state = 2;
        core_cnt   = BUSY_LEN;
      end
    end else if (core_state == 2) begin
      core_cnt--;
      if (core_cnt == 0) begin
        tx_busy    = 1'b0;
        core_state = 0;
        pend_inc   = 1;
      end
    end

    if (int'(frame_count) < prev_fc && reset_n) wrap_seen = 1;
    prev_fc = int'(frame_count);
    check("frame_count", int'(frame_count), model_frames % (1 << CNT_W));
    check("ack_onehot", int'($countones(req_ack) <= 1), 1);
    if (core_state != 0) check("tx_data_hold", tx_data, core_byte);

    if (req_ack != '0) begin
      int w;
      int a;
      w = expected_winner();
      a = -1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) a = i;
      check("grant_order", a, w);
      grant_log.push_back(a);
      if (w >= 0) begin
        last_grant = w;
`ifdef UART_TX_SCHED_SRC_HDR_EN
        exp_q.push_back({4'hA, 1'b0, 3'(w)});
`endif
        exp_q.push_back(req_data[8*w +: 8]);
      end
      if (a >= 0) begin
        req[a] = 1'b0;
        if (remaining[a] > 0) begin
          remaining[a]--;
          reassert[a] = 1'b1;
        end
      end
    end

    if (tx_start) begin
      start_cycles.push_back(cyc);
      check("start_while_core_busy", core_state, 0);
      check("start_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check("tx_data_at_start", tx_data, exp_q[0]);
        if (ignore_starts > 0) begin
          ignore_starts--;
        end else begin
          core_byte = exp_q.pop_front();
          core_log.push_back(core_byte);
          core_state = 1;
          core_cnt   = BUSY_DELAY;
        end
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    tick();
    tick();
    while (!(req == '0 && reassert == '0 && exp_q.size() == 0 && core_state == 0 && !sched_busy)
           && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles, limit %0d", n, limit);
    end
  endtask

  initial begin
    int gl0;
    int exp_order[5];
    reset_n       = 1'b0;
    req_data      = '0;
    core_byte     = 8'h00;
    ignore_starts = 0;
    cyc           = 0;
    prev_fc       = 0;
    wrap_seen     = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req_ack", req_ack, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_active_src", active_src, 0);
    check("rst_sched_busy", sched_busy, 0);
    check("rst_frame_count", frame_count, 0);
    reset_n = 1'b1;

    // Single requester 0.
    start_cycles.delete();
    req_data[7:0] = 8'h5A;
    req[0] = 1'b1;
    wait_idle(300);
    check("t1_frames", frame_count, (1 * FPG) % 16);
    check("t1_tx_data", tx_data, 8'h5A);
    check("t1_src", active_src, 0);
    check("t1_acks", grant_log.size(), 1);
    check("t1_starts", start_cycles.size(), FPG);
    check("t1_sched_busy", sched_busy, 0);

    // All four pending; requester 1 comes back with a second byte.
    gl0 = grant_log.size();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    remaining[1] = 1;
    req = 4'b1111;
    wait_idle(1000);
    exp_order = '{1, 2, 3, 0, 1};
    check("t2_grants", grant_log.size() - gl0, 5);
    for (int j = 0; j < 5; j++)
      if (gl0 + j < grant_log.size()) check("t2_order", grant_log[gl0 + j], exp_order[j]);
    check("t2_frames", frame_count, (6 * FPG) % 16);

    // Core ignores the first start pulse.
    start_cycles.delete();
    ignore_starts = 1;
    req_data[23:16] = 8'h3C;
    req[2] = 1'b1;
    wait_idle(500);
    check("t3_starts", start_cycles.size(), FPG + 1);
    if (start_cycles.size() >= 2) check("t3_retry_gap", start_cycles[1] - start_cycles[0], 5);
    check("t3_byte", core_log[$], 8'h3C);
    check("t3_frames", frame_count, (7 * FPG) % 16);

    // Requester 2, byte C3 (header build sends A2 first).
    gl0 = grant_log.size();
    req_data[23:16] = 8'hC3;
    req = 4'b0100;
    wait_idle(500);
    check("t6_acks", grant_log.size() - gl0, 1);
    check("t6_payload", core_log[$], 8'hC3);
`ifdef UART_TX_SCHED_SRC_HDR_EN
    check("t6_header", core_log[core_log.size() - 2], 8'hA2);
`endif
    check("t6_frames", frame_count, (8 * FPG) % 16);

    // Async reset while the core is mid-frame.
    req_data[15:8] = 8'h66;
    req = 4'b0010;
    for (int n = 0; n < 200 && core_state != 2; n++) tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_req_ack", req_ack, 0);
    check("arst_tx_start", tx_start, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_active_src", active_src, 0);
    check("arst_sched_busy", sched_busy, 0);
    check("arst_frame_count", frame_count, 0);
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;

    // 17 grants after reset: counter wraps, rotation restarts at 0.
    gl0 = grant_log.size();
    wrap_seen = 0;
    req_data = {8'h23, 8'h22, 8'h21, 8'h20};
    remaining[0] = 4;
    remaining[1] = 3;
    remaining[2] = 3;
    remaining[3] = 3;
    req = 4'b1111;
    wait_idle(4000);
    check("t5_grants", grant_log.size() - gl0, 17);
    if (grant_log.size() > gl0) check("t5_first_grant", grant_log[gl0], 0);
    check("t5_last_grant", grant_log[$], 0);
    check("t5_wrap_seen", wrap_seen, 1);
    check("t5_frames", frame_count, (17 * FPG) % 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one 8-bit UART transmitter core between NUM_REQ byte requesters.
- Latches one requester's byte, acknowledges the requester, then sequences the core through a start/busy handshake.
- Sits between user-side producers (status, debug, command responders) and the single tx line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of source index; must equal ceil(log2(NUM_REQ)).
- CNT_W, 16, width of the transmitted-frame counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester byte-pending level; held high until its ack.
- req_data  input  NUM_REQ*8  packed bytes; requester i owns bits [8i+7:8i]; stable while req[i] is high.
- req_ack  output  NUM_REQ  one-cycle pulse when requester i's byte is latched.
- tx_data  output  8  byte to the transmitter core; stable from tx_start until tx_busy falls.
- tx_start  output  1  one-cycle start pulse to the core.
- tx_busy  input  1  core busy; rises 1-2 cycles after tx_start, falls when the stop bit completes.
- active_src  output  IDX_W  index of the requester currently being served.
- sched_busy  output  1  high in every state except IDLE.
- frame_count  output  CNT_W  count of frames completed on the line.

Behaviour:
- Reset (async assert, sync release) clears req_ack, tx_start, tx_data, active_src, sched_busy and frame_count to 0, sets the round-robin pointer to NUM_REQ-1 (so requester 0 wins first), and sets state to IDLE.
- Reset mid-frame abandons the frame. tx_start is never reissued for it and no ack is repeated.
- States: IDLE, GRANT, START, WAIT_HI, WAIT_LO.
- IDLE:
  - if any req bit is high and tx_busy is low, go to GRANT next cycle.
  - if tx_busy is high, stay in IDLE.
- GRANT (1 cycle):
  - winner = first set req bit searching ptr+1, ptr+2, ... with wrap modulo NUM_REQ.
  - latch req_data slice into tx_data; active_src <= winner; ptr <= winner; pulse req_ack[winner].
  - go to START.
  - if req dropped to 0 between IDLE and GRANT, no ack is issued and state returns to IDLE.
- START: tx_start = 1 for exactly one cycle; go to WAIT_HI.
- WAIT_HI:
  - wait for tx_busy = 1, then go to WAIT_LO.
  - a 4-cycle timeout without busy returns to START and re-pulses tx_start. Retries are unlimited; the byte is never dropped.
- WAIT_LO:
  - on tx_busy = 0, frame_count increments (wraps at 2^CNT_W-1 -> 0) and state goes to IDLE.
  - back-to-back frames therefore cost 3 scheduler cycles of gap (WAIT_LO -> IDLE -> GRANT -> START).
- Fairness and acks:
  - simultaneous requests are served in rotation; a requester that holds req continuously receives at most one grant per NUM_REQ grants while others are pending.
  - at most one req_ack bit is high in any cycle.
  - a requester re-asserting req the cycle after its ack is treated as a new byte.
- tx_data and active_src hold their last values in IDLE.
- Only IDLE may accept a new grant; req changes in other states are ignored until IDLE.

Optional Feature:
- Macro: UART_TX_SCHED_SRC_HDR_EN.
- Defined: each granted byte is preceded by a header frame {4'hA, 1'b0, zero-extended source index in 3 bits}.
  - the header is sent via its own START/WAIT_HI/WAIT_LO pass using added states HDR_START, HDR_WAIT_HI and HDR_WAIT_LO, inserted between GRANT and START.
  - the payload is held in an internal register; tx_data shows the header during the header pass.
  - frame_count increments for both header and payload.
  - req_ack still pulses in GRANT.
- Undefined: header states and header register are absent; exactly one frame per grant.

Test Plan:
- Reset release, req = 4'b0001, data0 = 8'h5A, model core with busy 2 cycles after start for 20 cycles -> req_ack[0] pulse, tx_data = 8'h5A, single tx_start, frame_count = 1, sched_busy low after.
- req = 4'b1111 held, distinct bytes 8'h10..8'h13 -> grant order 0,1,2,3,0; no double ack; frame_count = 5 after five frames.
- Core ignores first tx_start (busy never rises) then responds -> tx_start re-pulsed after 4 cycles in WAIT_HI, byte unchanged, frame_count = 1.
- reset_n asserted during WAIT_LO of a frame -> all outputs 0 immediately (async); after release the next grant goes to requester 0.
- CNT_W = 4, 17 frames -> frame_count wraps 15 -> 0 -> 1.
- With UART_TX_SCHED_SRC_HDR_EN, req[2] with data 8'hC3 -> frames 8'hA2 then 8'hC3; frame_count = 2; one req_ack[2] pulse.
